img_ram_arbiter: RTL and testbench
==================================

Name: img_ram_arbiter

Overview:
- Shares one single-write-port frame RAM (1024x8, registered read) between two requesters.
- Requester m0 is the drawing/compositing controller (writes and read-modify-writes). Requester m1 is the LCD refresh engine (reads).
- Sits between those masters and the RAM instance, replacing direct wiring of both to the RAM ports.
- Provides a per-access req/ack handshake, round-robin arbitration with a burst limit, and read-data return tagged per requester.

Parameters:
- AW, 10, RAM address width.
- DW, 8, RAM data width.
- BURST_MAX, 16, maximum consecutive accesses granted to one requester while the other is requesting (legal range 1..255).
- RD_LAT, 1, RAM read latency in cycles from presented address to valid ram_rdata (legal range 1..4).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  m0 access request; held with its qualifiers until acked.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  AW  m0 access address.
- m0_wdata  in  DW  m0 write data.
- m0_ack  out  1  combinational; m0 access accepted this cycle.
- m0_rvalid  out  1  m0 read data valid this cycle.
- m0_rdata  out  DW  read data for m0, qualified by m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata: identical semantics for m1.
- ram_addr  out  AW  registered RAM address.
- ram_wdata  out  DW  registered RAM write data.
- ram_wren  out  1  registered RAM write enable.
- ram_rdata  in  DW  RAM read data.
- owner  out  2  registered; 00 none, 01 m0, 10 m1 (owner of the last accepted access).

Behaviour:
- Reset (rst=1 at a clock edge):
  - owner=00, burst_cnt=0, last_served=m1 (so m0 wins the first tie).
  - ram_addr=0, ram_wdata=0, ram_wren=0.
  - rvalid pipeline cleared; m0_rvalid=m1_rvalid=0; m0_rdata=m1_rdata=0.
  - While rst=1, m0_ack=m1_ack=0. Requests present during reset are not accepted and not lost; requesters keep req high.
- Handshake: an access is accepted in cycle n iff req=1 and ack=1 in cycle n. At most one ack per cycle. The requester may change req/addr/we/wdata after the edge ending cycle n. One access per cycle of sustained throughput.
- Grant decision (combinational, cycle n):
  - Only one requesting: grant it.
  - Both requesting, owner=none: grant the one not equal to last_served.
  - Both requesting, owner=X: grant X if burst_cnt<BURST_MAX, else the other requester.
- State update (edge ending cycle n):
  - On ack to requester Y: owner<=Y and last_served<=Y. burst_cnt<=burst_cnt+1 if Y==owner, else 1 (saturates at BURST_MAX).
  - No ack: owner<=none, burst_cnt<=0.
- RAM issue: on an ack in cycle n, ram_addr/ram_wdata/ram_wren are registered from the acked requester and valid in cycle n+1.
  - ram_wren=1 for exactly one cycle per accepted write; 0 for reads and idle cycles.
  - ram_addr and ram_wdata hold their last values when idle.
- Read return: an accepted read in cycle n produces rvalid=1 for exactly one cycle, at cycle n+1+RD_LAT, on the originating port only.
  - rdata of that port is registered from ram_rdata alongside rvalid and holds until the next rvalid on that port.
  - The rvalid pipeline is a (RD_LAT+1)-deep shift register of {valid, port}.
- Ordering and coherence: accesses reach the RAM in acceptance order. A read accepted after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads are dropped (no rvalid). A write accepted in the cycle before reset still reaches ram_wren in the reset cycle, but ram_wren is forced 0 by reset.
- Starvation bound: with both requesting continuously, neither waits more than BURST_MAX cycles.

Test Plan:
- Single read: m0 reads addr 0x005 holding 0xA5, m1 idle -> m0_ack in cycle 0; ram_addr=0x005, ram_wren=0 in cycle 1; m0_rvalid=1, m0_rdata=0xA5 in cycle 2 (RD_LAT=1); m1_rvalid stays 0.
- Write then read: m0 writes 0x3C to 0x3FF, next cycle m0 reads 0x3FF -> ram_wren pulses once in cycle 1; m0_rdata=0x3C with m0_rvalid in cycle 3.
- Simultaneous first requests after reset: m0 and m1 read in cycle 0 -> m0 acked cycle 0, owner=01; m0 drops req, m1 acked cycle 1; rvalid on m0 at cycle 2, on m1 at cycle 3.
- Burst limit: BURST_MAX=4, m0 and m1 request continuously -> ack pattern m0×4, m1×4, m0×4...; owner toggles every 4 cycles; no gaps in ram access.
- Uncontended streaming: m1 reads 1024 sequential addresses with m0 idle -> 1024 consecutive acks, no burst break; 1024 rvalid pulses in address order.
- Reset mid-read: m1 read acked in cycle 5, rst=1 in cycle 6 -> no m1_rvalid afterwards; all outputs return to reset values in cycle 7; a m0 request held through reset is acked in the first cycle after rst falls.

Source files
------------

// File: rtl/img_ram_arbiter_if.sv
// img_ram_arbiter_if
//   Groups the two requester handshakes and the RAM-side bus of img_ram_arbiter.
//   slave  : the arbiter (consumes m*_req/we/addr/wdata and ram_rdata,
//            produces m*_ack/rvalid/rdata, ram_addr/wdata/wren, owner).
//   master : the surrounding system (requesters plus RAM instance).
//   m*_req/we/addr/wdata : per-requester access request and qualifiers
//   m*_ack               : access accepted this cycle (combinational)
//   m*_rvalid/rdata      : read data return for that requester
//   ram_addr/wdata/wren  : registered RAM access
//   ram_rdata            : RAM read data
//   owner                : 00 none, 01 m0, 10 m1 (owner of last accepted access)
interface img_ram_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_rdata;
  logic [1:0]    owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_rdata,
    output m0_ack, m0_rvalid, m0_rdata,
    output m1_ack, m1_rvalid, m1_rdata,
    output ram_addr, ram_wdata, ram_wren, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_rdata,
    input  m0_ack, m0_rvalid, m0_rdata,
    input  m1_ack, m1_rvalid, m1_rdata,
    input  ram_addr, ram_wdata, ram_wren, owner
  );
endinterface

// File: rtl/img_ram_arbiter.sv
// img_ram_arbiter
//   Shares one single-write-port frame RAM between the drawing controller (m0)
//   and the LCD refresh engine (m1). Per-access req/ack handshake, round-robin
//   arbitration with a burst limit, registered RAM issue and per-port tagged
//   read return.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : img_ram_arbiter_if.slave (requester handshakes + RAM bus)
module img_ram_arbiter #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  img_ram_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

  localparam logic [7:0] LP_BMAX = 8'(BURST_MAX);

  owner_e        r_owner;
  logic [7:0]    r_burst_cnt;
  logic          r_last_m1;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  logic          r_ram_wren;
  logic [RD_LAT:0] r_pipe_vld;
  logic [RD_LAT:0] r_pipe_port;   // 0 = m0, 1 = m1
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_same;
  logic [7:0]    w_burst_nxt;
  logic          w_rv0;
  logic          w_rv1;

  // Grant decision; no grant while in reset so held requests survive it.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (bus.m0_req && !bus.m1_req) begin
        w_gnt0 = 1'b1;
      end else if (!bus.m0_req && bus.m1_req) begin
        w_gnt1 = 1'b1;
      end else if (bus.m0_req && bus.m1_req) begin
        case (r_owner)
          OWN_M0: begin
            if (r_burst_cnt < LP_BMAX) w_gnt0 = 1'b1;
            else                       w_gnt1 = 1'b1;
          end
          OWN_M1: begin
            if (r_burst_cnt < LP_BMAX) w_gnt1 = 1'b1;
            else                       w_gnt0 = 1'b1;
          end
          default: begin
            if (r_last_m1) w_gnt0 = 1'b1;
            else           w_gnt1 = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_same      = (w_gnt0 && (r_owner == OWN_M0)) || (w_gnt1 && (r_owner == OWN_M1));
    w_burst_nxt = 8'd1;
    if (w_same) begin
      w_burst_nxt = (r_burst_cnt >= LP_BMAX) ? r_burst_cnt : 8'(r_burst_cnt + 8'd1);
    end
  end

  // Last pipeline stage lines up with ram_rdata of the tagged access.
  assign w_rv0 = r_pipe_vld[RD_LAT] && !r_pipe_port[RD_LAT] && !rst;
  assign w_rv1 = r_pipe_vld[RD_LAT] &&  r_pipe_port[RD_LAT] && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_NONE;
      r_burst_cnt <= '0;
      r_last_m1   <= 1'b1;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_wren  <= 1'b0;
      r_pipe_vld  <= '0;
      r_pipe_port <= '0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_ram_wren     <= 1'b0;
      r_pipe_vld[0]  <= 1'b0;
      r_pipe_port[0] <= 1'b0;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_port[i] <= r_pipe_port[i-1];
      end

      if (w_gnt0) begin
        r_owner        <= OWN_M0;
        r_last_m1      <= 1'b0;
        r_burst_cnt    <= w_burst_nxt;
        r_ram_addr     <= bus.m0_addr;
        r_ram_wdata    <= bus.m0_wdata;
        r_ram_wren     <= bus.m0_we;
        r_pipe_vld[0]  <= !bus.m0_we;
        r_pipe_port[0] <= 1'b0;
      end else if (w_gnt1) begin
        r_owner        <= OWN_M1;
        r_last_m1      <= 1'b1;
        r_burst_cnt    <= w_burst_nxt;
        r_ram_addr     <= bus.m1_addr;
        r_ram_wdata    <= bus.m1_wdata;
        r_ram_wren     <= bus.m1_we;
        r_pipe_vld[0]  <= !bus.m1_we;
        r_pipe_port[0] <= 1'b1;
      end else begin
        r_owner     <= OWN_NONE;
        r_burst_cnt <= '0;
      end

      if (w_rv0) r_m0_rdata <= bus.ram_rdata;
      if (w_rv1) r_m1_rdata <= bus.ram_rdata;
    end
  end

  assign bus.m0_ack    = w_gnt0;
  assign bus.m1_ack    = w_gnt1;
  assign bus.m0_rvalid = w_rv0;
  assign bus.m1_rvalid = w_rv1;
  // Data is forwarded in its valid cycle, then the captured copy is held.
  assign bus.m0_rdata  = w_rv0 ? bus.ram_rdata : r_m0_rdata;
  assign bus.m1_rdata  = w_rv1 ? bus.ram_rdata : r_m1_rdata;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_wren  = r_ram_wren;
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_img_ram_arbiter.sv
// tb_img_ram_arbiter
//   Directed bench for img_ram_arbiter (BURST_MAX=4, RD_LAT=1) with a
//   1024x8 registered-read RAM model on the RAM side.
module tb_img_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  img_ram_arbiter_if #(.AW(10), .DW(8)) bus ();

  img_ram_arbiter #(
    .AW(10), .DW(8), .BURST_MAX(4), .RD_LAT(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [7:0] init_val(int a);
    if (a == 5) return 8'hA5;
    return 8'(a * 7 + 3);
  endfunction

  // RAM model: one write port, read data valid the cycle after the address.
  logic [7:0] mem [0:1023];
  logic [7:0] ram_q;
  logic       mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
      ram_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = ram_q;

  logic [7:0] exp_mem [0:1023];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_reqs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
  endtask

  task automatic apply_reset();
    tick(); rst = 1'b1; idle_reqs();
    tick();
    tick(); rst = 1'b0;
  endtask

  initial begin
    int n_ack, n_rv, n_bad, n_stray, exp_idx;
    logic exp_g0;

    for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(i);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'h005; bus.m0_wdata = 8'h00;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 10'h000; bus.m1_wdata = 8'h00;

    // Reset with m0 request pending: no ack, outputs at reset values.
    tick(); settle();
    check_eq("rst_m0_ack", bus.m0_ack, 0);
    check_eq("rst_owner", bus.owner, 0);
    check_eq("rst_ram_addr", bus.ram_addr, 0);
    check_eq("rst_ram_wren", bus.ram_wren, 0);
    check_eq("rst_m0_rvalid", bus.m0_rvalid, 0);
    check_eq("rst_m0_rdata", bus.m0_rdata, 0);
    tick(); settle();
    check_eq("rst2_m0_ack", bus.m0_ack, 0);

    // Single read of 0x005 by m0.
    tick(); rst = 1'b0; settle();
    check_eq("rd_c0_m0_ack", bus.m0_ack, 1);
    check_eq("rd_c0_m1_ack", bus.m1_ack, 0);
    tick(); bus.m0_req = 1'b0; settle();
    check_eq("rd_c1_ram_addr", bus.ram_addr, 10'h005);
    check_eq("rd_c1_ram_wren", bus.ram_wren, 0);
    check_eq("rd_c1_owner", bus.owner, 2'b01);
    check_eq("rd_c1_m0_rvalid", bus.m0_rvalid, 0);
    tick(); settle();
    check_eq("rd_c2_m0_rvalid", bus.m0_rvalid, 1);
    check_eq("rd_c2_m0_rdata", bus.m0_rdata, 8'hA5);
    check_eq("rd_c2_m1_rvalid", bus.m1_rvalid, 0);
    check_eq("rd_c2_owner", bus.owner, 2'b00);
    tick(); settle();
    check_eq("rd_c3_m0_rvalid", bus.m0_rvalid, 0);
    check_eq("rd_c3_m0_rdata_hold", bus.m0_rdata, 8'hA5);

    // Write 0x3C to 0x3FF then read it back.
    tick(); bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 10'h3FF; bus.m0_wdata = 8'h3C;
    exp_mem[10'h3FF] = 8'h3C;
    settle();
    check_eq("wr_c0_ack", bus.m0_ack, 1);
    tick(); bus.m0_we = 1'b0; settle();
    check_eq("wr_c1_ack", bus.m0_ack, 1);
    check_eq("wr_c1_wren", bus.ram_wren, 1);
    check_eq("wr_c1_addr", bus.ram_addr, 10'h3FF);
    check_eq("wr_c1_wdata", bus.ram_wdata, 8'h3C);
    tick(); bus.m0_req = 1'b0; settle();
    check_eq("wr_c2_wren", bus.ram_wren, 0);
    check_eq("wr_c2_m0_rvalid", bus.m0_rvalid, 0);
    tick(); settle();
    check_eq("wr_c3_m0_rvalid", bus.m0_rvalid, 1);
    check_eq("wr_c3_m0_rdata", bus.m0_rdata, 8'h3C);

    // Simultaneous first requests after reset.
    apply_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 10'h010;
    bus.m1_req = 1'b1; bus.m1_addr = 10'h020;
    settle();
    check_eq("sim_c0_m0_ack", bus.m0_ack, 1);
    check_eq("sim_c0_m1_ack", bus.m1_ack, 0);
    tick(); bus.m0_req = 1'b0; settle();
    check_eq("sim_c1_m1_ack", bus.m1_ack, 1);
    check_eq("sim_c1_owner", bus.owner, 2'b01);
    tick(); bus.m1_req = 1'b0; settle();
    check_eq("sim_c2_m0_rvalid", bus.m0_rvalid, 1);
    check_eq("sim_c2_m0_rdata", bus.m0_rdata, exp_mem[10'h010]);
    check_eq("sim_c2_m1_rvalid", bus.m1_rvalid, 0);
    check_eq("sim_c2_owner", bus.owner, 2'b10);
    tick(); settle();
    check_eq("sim_c3_m1_rvalid", bus.m1_rvalid, 1);
    check_eq("sim_c3_m1_rdata", bus.m1_rdata, exp_mem[10'h020]);
    check_eq("sim_c3_m0_rvalid", bus.m0_rvalid, 0);

    // Burst limit 4 with both requesting continuously.
    apply_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 10'h100;
    bus.m1_req = 1'b1; bus.m1_addr = 10'h200;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      settle();
      exp_g0 = (((k / 4) % 2) == 0);
      check_eq($sformatf("burst_m0_ack_%0d", k), bus.m0_ack, exp_g0);
      check_eq($sformatf("burst_m1_ack_%0d", k), bus.m1_ack, !exp_g0);
      if (k > 0) begin
        exp_g0 = ((((k - 1) / 4) % 2) == 0);
        check_eq($sformatf("burst_owner_%0d", k), bus.owner, exp_g0 ? 2'b01 : 2'b10);
        check_eq($sformatf("burst_addr_%0d", k), bus.ram_addr, exp_g0 ? 10'h100 : 10'h200);
      end else begin
        check_eq("burst_owner_0", bus.owner, 2'b00);
      end
    end
    tick(); idle_reqs();
    tick(); tick(); tick();

    // Uncontended streaming by m1 over the whole RAM.
    n_ack = 0; n_rv = 0; n_bad = 0; n_stray = 0; exp_idx = 0;
    for (int k = 0; k < 1026; k++) begin
      if (k > 0) tick();
      bus.m1_req  = (k < 1024);
      bus.m1_we   = 1'b0;
      bus.m1_addr = 10'(k);
      settle();
      if (bus.m1_ack) n_ack++;
      if (bus.m0_ack || bus.m0_rvalid) n_stray++;
      if (bus.m1_rvalid) begin
        n_rv++;
        if (exp_idx > 1023 || bus.m1_rdata !== exp_mem[exp_idx]) n_bad++;
        exp_idx++;
      end
    end
    check_eq("stream_acks", n_ack, 1024);
    check_eq("stream_rvalids", n_rv, 1024);
    check_eq("stream_data_errs", n_bad, 0);
    check_eq("stream_m0_stray", n_stray, 0);

    // Reset while an m1 read is in flight; m0 request held through reset.
    apply_reset();
    tick(); tick(); tick(); tick();
    tick(); bus.m1_req = 1'b1; bus.m1_addr = 10'h033; settle();
    check_eq("mid_c5_m1_ack", bus.m1_ack, 1);
    tick(); rst = 1'b1; bus.m1_req = 1'b0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'h044;
    settle();
    check_eq("mid_c6_m0_ack", bus.m0_ack, 0);
    check_eq("mid_c6_ram_addr", bus.ram_addr, 10'h033);
    tick(); rst = 1'b0; settle();
    check_eq("mid_c7_owner", bus.owner, 0);
    check_eq("mid_c7_ram_addr", bus.ram_addr, 0);
    check_eq("mid_c7_m1_rvalid", bus.m1_rvalid, 0);
    check_eq("mid_c7_m1_rdata", bus.m1_rdata, 0);
    check_eq("mid_c7_m0_ack", bus.m0_ack, 1);
    tick(); bus.m0_req = 1'b0; settle();
    check_eq("mid_c8_m1_rvalid", bus.m1_rvalid, 0);
    check_eq("mid_c8_ram_addr", bus.ram_addr, 10'h044);
    tick(); settle();
    check_eq("mid_c9_m0_rvalid", bus.m0_rvalid, 1);
    check_eq("mid_c9_m0_rdata", bus.m0_rdata, exp_mem[10'h044]);
    check_eq("mid_c9_m1_rvalid", bus.m1_rvalid, 0);

    // Write accepted the cycle before reset still drives ram_wren in that cycle.
    tick(); bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 10'h0AA; bus.m0_wdata = 8'h77;
    settle();
    check_eq("wrst_ack", bus.m0_ack, 1);
    tick(); rst = 1'b1; idle_reqs(); settle();
    check_eq("wrst_wren_in_rst", bus.ram_wren, 1);
    check_eq("wrst_wdata_in_rst", bus.ram_wdata, 8'h77);
    tick(); rst = 1'b0; settle();
    check_eq("wrst_wren_after", bus.ram_wren, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
